bar_graph_renderer: RTL and testbench

//  Consumer of the 24-bit band-level word (inAmpFreq) from the input/filter stage. On each start,

---
 rtl/bar_graph_renderer_pkg.sv | 37 +++
 rtl/bar_graph_renderer_if.sv | 24 ++
 rtl/bar_graph_renderer_pixel_colour.sv | 27 ++
 rtl/bar_graph_renderer.sv | 139 +++++++++++++
 tb/tb_bar_graph_renderer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bar_graph_renderer_pkg.sv
// Shared geometry, widths and FSM encoding for the bar-graph framebuffer painter.
package bar_graph_renderer_pkg;

   localparam int unsigned BANDS      = 8;
   localparam int unsigned LVL_W      = 3;
   localparam int unsigned BAR_W      = 20;
   localparam int unsigned SCR_W      = 160;
   localparam int unsigned SCR_H      = 120;
   localparam int unsigned STEP       = 15;
   localparam int unsigned COLOUR_MOD = 7;

   localparam int unsigned AMP_W  = BANDS * LVL_W;
   localparam int unsigned X_W    = 8;
   localparam int unsigned Y_W    = 7;
   localparam int unsigned COL_W  = 3;
   localparam int unsigned BAND_W = 3;
   localparam int unsigned BCOL_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Mux one band's level out of the packed snapshot without a variable-width index.
   function automatic logic [LVL_W-1:0] band_level(input logic [AMP_W-1:0] snap,
                                                   input logic [BAND_W-1:0] band);
      logic [LVL_W-1:0] lvl;
      lvl = '0;
      for (int k = 0; k < int'(BANDS); k++) begin
         if (BAND_W'(k) == band) lvl = snap[k*LVL_W +: LVL_W];
      end
      return lvl;
   endfunction

endpackage

// File: rtl/bar_graph_renderer_if.sv
// Repaint request/status plus the VGA adapter pixel-write port.
interface bar_graph_renderer_if;
   import bar_graph_renderer_pkg::*;

   logic                 start;
   logic [AMP_W-1:0]     inAmpFreq;
   logic [X_W-1:0]       x;
   logic [Y_W-1:0]       y;
   logic [COL_W-1:0]     colour;
   logic                 plot;
   logic                 busy;
   logic                 done;

   modport master (
      output start, inAmpFreq,
      input  x, y, colour, plot, busy, done
   );

   modport slave (
      input  start, inAmpFreq,
      output x, y, colour, plot, busy, done
   );

endinterface

// File: rtl/bar_graph_renderer_pixel_colour.sv
// Colour of one pixel given its band, the band's level and the row (0 = top).
module bar_pixel_colour
   import bar_graph_renderer_pkg::*;
(
   input  logic [BAND_W-1:0] i_band,
   input  logic [LVL_W-1:0]  i_level,
   input  logic [Y_W-1:0]    i_row,
   output logic [COL_W-1:0]  o_colour_c
);

   logic [Y_W-1:0]   w_height;
   logic [Y_W:0]     w_sum;
   logic             w_lit;
   logic [COL_W-1:0] w_band_colour;

   // Bar grows up from the bottom edge; 8-bit sum so row+height never wraps.
   assign w_height = Y_W'(i_level) * Y_W'(STEP);
   assign w_sum    = {1'b0, i_row} + {1'b0, w_height};
   assign w_lit    = (w_sum >= (Y_W+1)'(SCR_H));

   // Palette skips black so a lit bar is always visible.
   assign w_band_colour = (i_band >= BAND_W'(COLOUR_MOD)) ? COL_W'(1)
                                                          : COL_W'(i_band) + COL_W'(1);

   assign o_colour_c = w_lit ? w_band_colour : '0;

endmodule

// File: rtl/bar_graph_renderer.sv
// Repaints the framebuffer as BANDS vertical bars, one pixel per cycle, column-major scan.
module bar_graph_renderer
   import bar_graph_renderer_pkg::*;
(
   input logic                 clk,
   input logic                 resetn,
   bar_graph_renderer_if.slave bus
);

   state_t             r_state,  w_nxt_state;
   logic [AMP_W-1:0]   r_snap,   w_nxt_snap;
   logic [BAND_W-1:0]  r_band,   w_nxt_band;
   logic [BCOL_W-1:0]  r_col,    w_nxt_col;
   logic [X_W-1:0]     r_x,      w_nxt_x;
   logic [Y_W-1:0]     r_y,      w_nxt_y;
   logic [COL_W-1:0]   r_colour, w_nxt_colour;
   logic               r_plot,   w_nxt_plot;
   logic               r_busy,   w_nxt_busy;
   logic               r_done,   w_nxt_done;

   logic [COL_W-1:0]   w_pix_colour;
   logic [LVL_W-1:0]   w_level;
   logic               w_last_row;
   logic               w_last_col;
   logic               w_last_band;

   assign w_last_row  = (r_y    == Y_W'(SCR_H - 1));
   assign w_last_col  = (r_col  == BCOL_W'(BAR_W - 1));
   assign w_last_band = (r_band == BAND_W'(BANDS - 1));

   // Colour is evaluated for the pixel about to be registered onto the outputs.
   assign w_level = band_level(r_snap, w_nxt_band);

   bar_pixel_colour u_pixel_colour (
      .i_band     (w_nxt_band),
      .i_level    (w_level),
      .i_row      (w_nxt_y),
      .o_colour_c (w_pix_colour)
   );

   assign w_nxt_colour = w_nxt_plot ? w_pix_colour : '0;

   // Next-state, scan counters and registered-output values.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_snap  = r_snap;
      w_nxt_band  = r_band;
      w_nxt_col   = r_col;
      w_nxt_x     = r_x;
      w_nxt_y     = r_y;
      w_nxt_plot  = 1'b0;
      w_nxt_busy  = 1'b0;
      w_nxt_done  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_nxt_state = ST_LATCH;
               w_nxt_snap  = bus.inAmpFreq;
               w_nxt_band  = '0;
               w_nxt_col   = '0;
               w_nxt_x     = '0;
               w_nxt_y     = '0;
               w_nxt_busy  = 1'b1;
            end
         end

         ST_LATCH: begin
            w_nxt_state = ST_DRAW;
            w_nxt_plot  = 1'b1;
            w_nxt_busy  = 1'b1;
         end

         ST_DRAW: begin
            if (w_last_row && w_last_col && w_last_band) begin
               w_nxt_state = ST_DONE;
               w_nxt_done  = 1'b1;
            end else begin
               w_nxt_plot = 1'b1;
               w_nxt_busy = 1'b1;
               if (w_last_row) begin
                  w_nxt_y = '0;
                  w_nxt_x = r_x + X_W'(1);
                  if (w_last_col) begin
                     w_nxt_col  = '0;
                     w_nxt_band = r_band + BAND_W'(1);
                  end else begin
                     w_nxt_col = r_col + BCOL_W'(1);
                  end
               end else begin
                  w_nxt_y = r_y + Y_W'(1);
               end
            end
         end

         ST_DONE: begin
            w_nxt_state = ST_IDLE;
         end

         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_snap   <= '0;
         r_band   <= '0;
         r_col    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_snap   <= w_nxt_snap;
         r_band   <= w_nxt_band;
         r_col    <= w_nxt_col;
         r_x      <= w_nxt_x;
         r_y      <= w_nxt_y;
         r_colour <= w_nxt_colour;
         r_plot   <= w_nxt_plot;
         r_busy   <= w_nxt_busy;
         r_done   <= w_nxt_done;
      end
   end

   assign bus.x      = r_x;
   assign bus.y      = r_y;
   assign bus.colour = r_colour;
   assign bus.plot   = r_plot;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_bar_graph_renderer.sv
// Self-checking bench for bar_graph_renderer: pixel scoreboard, probe table, multi-cycle corner cases.
module tb_bar_graph_renderer;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   bar_graph_renderer_if bus ();

   bar_graph_renderer dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   typedef struct {
      logic [23:0] amp;
      bit          chg;
      bit          rep;
   } frame_t;

   typedef struct {
      int f;
      int px;
      int py;
      int c;
   } probe_t;

   pix_t       exp_q[$];
   logic [2:0] fb [0:159][0:119];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int plot_cnt = 0;
   int first_plot_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic prev_done = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference colour from screen coordinates (division is fine here).
   function automatic logic [2:0] model_colour(input logic [23:0] amp, input int x, input int y);
      int band, lvl, h;
      band = x / 20;
      lvl  = int'((amp >> (3 * band)) & 24'h7);
      h    = lvl * 15;
      if (y + h >= 120) return 3'((band % 7) + 1);
      return 3'd0;
   endfunction

   task automatic push_frame(input logic [23:0] amp);
      pix_t p;
      for (int xi = 0; xi < 160; xi++) begin
         for (int yi = 0; yi < 120; yi++) begin
            p.x = 8'(xi);
            p.y = 7'(yi);
            p.c = model_colour(amp, xi, yi);
            exp_q.push_back(p);
         end
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor on the falling edge.
   always @(negedge clk) begin
      pix_t e;
      if (bus.done) begin
         check("done_one_cycle", int'(prev_done), 0);
         done_cnt++;
         done_cyc = cyc;
      end
      prev_done = bus.done;
      if (bus.plot) begin
         plot_cnt++;
         if (plot_cnt == 1) first_plot_cyc = cyc;
         check("plot_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pixel_xyc", int'({bus.x, bus.y, bus.colour}), int'({e.x, e.y, e.c}));
         end
         if (bus.x < 8'd160 && bus.y < 7'd120) fb[bus.x][bus.y] = bus.colour;
      end
   end

   // Start presented right after edge N; expects first plot at N+2 and done at N+19202.
   task automatic run_frame(input logic [23:0] amp, input bit chg, input bit rep);
      int n, d0;
      bit ok;
      @(posedge clk); #1;
      n = cyc;
      d0 = done_cnt;
      plot_cnt = 0;
      bus.inAmpFreq = amp;
      bus.start = 1'b1;
      push_frame(amp);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_in_latch", int'(bus.busy), 1);
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(posedge clk); #1;
         if (chg && plot_cnt >= 100) bus.inAmpFreq = '0;
         if (rep) bus.start = (plot_cnt >= 3000 && plot_cnt < 3003);
         if (done_cnt != d0) ok = 1'b1;
      end
      bus.start = 1'b0;
      check("done_seen", int'(ok), 1);
      check("done_latency", done_cyc - n, 19202);
      check("first_plot_latency", first_plot_cyc - n, 2);
      check("plot_count", plot_cnt, 19200);
      check("queue_drained", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_no_plot", plot_cnt, 19200);
      check("idle_busy", int'(bus.busy), 0);
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(posedge clk); #1;
         if (done_cnt >= target) ok = 1'b1;
      end
   endtask

   frame_t frames[4];
   probe_t probes[$];

   initial begin
      int d0, d1, n;
      bit ok;

      frames[0] = '{24'h000000, 1'b0, 1'b0};
      frames[1] = '{24'h000007, 1'b0, 1'b0};
      frames[2] = '{24'hFFFFFF, 1'b1, 1'b0};
      frames[3] = '{24'hFAC688, 1'b0, 1'b1};   // band k at level k

      probes = '{
         '{0, 0, 119, 0}, '{0, 159, 119, 0}, '{0, 80, 60, 0},
         '{1, 0, 14, 0},  '{1, 0, 15, 1},    '{1, 19, 119, 1}, '{1, 20, 119, 0}, '{1, 159, 119, 0},
         '{2, 120, 15, 7}, '{2, 140, 50, 1}, '{2, 40, 14, 0},  '{2, 40, 15, 3},  '{2, 159, 119, 1},
         '{2, 0, 0, 0},
         '{3, 60, 74, 0}, '{3, 60, 75, 4},   '{3, 100, 45, 6}, '{3, 119, 44, 0}, '{3, 10, 119, 0},
         '{3, 159, 15, 1}, '{3, 159, 14, 0}
      };

      bus.start = 1'b0;
      bus.inAmpFreq = '0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_plot",   int'(bus.plot), 0);
      check("rst_busy",   int'(bus.busy), 0);
      check("rst_done",   int'(bus.done), 0);
      check("rst_x",      int'(bus.x), 0);
      check("rst_y",      int'(bus.y), 0);
      check("rst_colour", int'(bus.colour), 0);

      // Table-driven frames with probe points
      for (int f = 0; f < 4; f++) begin
         run_frame(frames[f].amp, frames[f].chg, frames[f].rep);
         foreach (probes[i]) begin
            if (probes[i].f == f)
               check($sformatf("probe_f%0d_x%0d_y%0d", f, probes[i].px, probes[i].py),
                     int'(fb[probes[i].px][probes[i].py]), probes[i].c);
         end
      end

      // Start held high: back-to-back frames, second re-snapshots the input
      @(posedge clk); #1;
      n = cyc;
      d0 = done_cnt;
      plot_cnt = 0;
      bus.inAmpFreq = 24'hFAC688;
      bus.start = 1'b1;
      push_frame(24'hFAC688);
      wait_done(d0 + 1, ok);
      check("b2b_done1_seen", int'(ok), 1);
      d1 = done_cyc;
      check("b2b_done1_latency", d1 - n, 19202);
      bus.inAmpFreq = 24'h000007;
      push_frame(24'h000007);
      wait_done(d0 + 2, ok);
      bus.start = 1'b0;
      check("b2b_done2_seen", int'(ok), 1);
      check("b2b_done_spacing", done_cyc - d1, 19203);
      check("b2b_plot_count", plot_cnt, 38400);
      check("b2b_queue_drained", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      check("b2b_stopped", plot_cnt, 38400);
      check("b2b_probe_band0", int'(fb[5][20]), 1);
      check("b2b_probe_band3", int'(fb[65][119]), 0);

      // Reset asserted mid-frame aborts without a done pulse
      @(posedge clk); #1;
      d0 = done_cnt;
      plot_cnt = 0;
      bus.inAmpFreq = 24'hFFFFFF;
      bus.start = 1'b1;
      push_frame(24'hFFFFFF);
      @(posedge clk); #1;
      bus.start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 6000 && !ok; i++) begin
         @(posedge clk); #1;
         if (plot_cnt >= 5000) ok = 1'b1;
      end
      check("abort_reached_5000", int'(ok), 1);
      resetn = 1'b0;
      #1;
      check("abort_plot_async", int'(bus.plot), 0);
      check("abort_busy_async", int'(bus.busy), 0);
      check("abort_x_async", int'(bus.x), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, d0);
      run_frame(24'hFAC688, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
